// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD countdown timer.
// The DUT side uses the slave modport and the driving side uses the master modport.
interface bcd_down_timer_if #(
  parameter int DIGITS = 2
);
  localparam int W = 4 * DIGITS;

  logic         clk_en;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic [W-1:0] cnt_out;
  logic         bo;
  logic         done_pulse;
  logic         busy;
  logic [1:0]   state;

  modport master (
    output clk_en, clr, load, load_val, start, pause,
    input  cnt_out, bo, done_pulse, busy, state
  );

  modport slave (
    input  clk_en, clr, load, load_val, start, pause,
    output cnt_out, bo, done_pulse, busy, state
  );
endinterface

// File: rtl/bcd_down_timer.sv
// Cascaded BCD countdown timer with IDLE/RUN/PAUSE/DONE control FSM.
// Optional auto-reload on expiry is enabled by defining BCD_TIMER_RELOAD_EN.
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  bcd_down_timer_if.slave   bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;
`ifdef BCD_TIMER_RELOAD_EN
  logic [W-1:0] reload_q, reload_d;
`endif

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] res;
    res = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) res[4*d +: 4] = 4'd9;
    end
    return res;
  endfunction

  // Borrow ripples upward: a zero digit wraps to 9 and passes the borrow on.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    res    = v;
    borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (borrow) begin
        if (v[4*d +: 4] != 4'd0) begin
          res[4*d +: 4] = v[4*d +: 4] - 4'd1;
          borrow        = 1'b0;
        end else begin
          res[4*d +: 4] = 4'd9;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef BCD_TIMER_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.clr) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (bus.load) begin
      cnt_d   = clamp_bcd(bus.load_val);
      state_d = IDLE;
`ifdef BCD_TIMER_RELOAD_EN
      reload_d = clamp_bcd(bus.load_val);
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.pause) begin
            if (cnt_q != '0) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (bus.clk_en) begin
            if (cnt_q == ONE) begin
              done_d  = 1'b1;
`ifdef BCD_TIMER_RELOAD_EN
              if (reload_q != '0) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = DONE;
              end
`else
              cnt_d   = '0;
              state_d = DONE;
`endif
            end else begin
              cnt_d = dec_bcd(cnt_q);
            end
          end
        end
        PAUSE: begin
          if (bus.start && !bus.pause) state_d = RUN;
        end
        DONE: begin
          cnt_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef BCD_TIMER_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef BCD_TIMER_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.cnt_out    = cnt_q;
  assign bus.bo         = (cnt_q == '0);
  assign bus.done_pulse = done_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.state      = state_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer (DIGITS=2).
// Expectations follow BCD_TIMER_RELOAD_EN when it is defined for the build.
module tb_bcd_down_timer;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  bcd_down_timer_if #(.DIGITS(2)) bus ();

  bcd_down_timer #(.DIGITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    logic [7:0] seq1 [11];
    logic [7:0] e_cnt;
    logic       e_done;
    logic [1:0] e_state;
    int         k;

    n_cmp = 0;
    n_bad = 0;
    seq1 = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

    rst = 1'b1;
    bus.clk_en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0;
    bus.load_val = 8'h00; bus.start = 1'b0; bus.pause = 1'b0;
    cycle();
    cycle();
    chk("rst_cnt",   bus.cnt_out, 8'h00);
    chk("rst_state", bus.state, 2'd0);
    chk("rst_done",  bus.done_pulse, 1'b0);
    chk("rst_bo",    bus.bo, 1'b1);
    chk("rst_busy",  bus.busy, 1'b0);
    rst = 1'b0;
    cycle();

    // Load 12, run twelve ticks down to expiry
    bus.load = 1'b1; bus.load_val = 8'h12;
    cycle();
    bus.load = 1'b0;
    chk("t1_load", bus.cnt_out, 8'h12);
    chk("t1_idle", bus.state, 2'd0);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("t1_run",  bus.state, 2'd1);
    chk("t1_busy", bus.busy, 1'b1);
    bus.clk_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cycle();
      chk("t1_cnt", bus.cnt_out, seq1[i]);
      chk("t1_nodone", bus.done_pulse, 1'b0);
    end
    cycle();
    bus.clk_en = 1'b0;
    chk("t1_done", bus.done_pulse, 1'b1);
`ifdef BCD_TIMER_RELOAD_EN
    chk("t1_reload_cnt", bus.cnt_out, 8'h12);
    chk("t1_reload_state", bus.state, 2'd1);
`else
    chk("t1_zero_cnt", bus.cnt_out, 8'h00);
    chk("t1_state_done", bus.state, 2'd3);
    chk("t1_bo", bus.bo, 1'b1);
`endif
    cycle();
    chk("t1_done_once", bus.done_pulse, 1'b0);

    // Multi-digit borrow, then start from zero
    bus.load = 1'b1; bus.load_val = 8'h30;
    cycle();
    bus.load = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0; bus.clk_en = 1'b1;
    cycle();
    bus.clk_en = 1'b0;
    chk("t2_borrow", bus.cnt_out, 8'h29);
    bus.load = 1'b1; bus.load_val = 8'h00;
    cycle();
    bus.load = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("t2_zero_state", bus.state, 2'd3);
    chk("t2_zero_done", bus.done_pulse, 1'b1);
    cycle();
    chk("t2_zero_done_clr", bus.done_pulse, 1'b0);

    // Pause beats start and tick; paused ticks are ignored
    bus.load = 1'b1; bus.load_val = 8'h05;
    cycle();
    bus.load = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0; bus.clk_en = 1'b1;
    cycle();
    chk("t3_tick", bus.cnt_out, 8'h04);
    bus.pause = 1'b1; bus.start = 1'b1;
    cycle();
    bus.pause = 1'b0; bus.start = 1'b0;
    chk("t3_pause_cnt", bus.cnt_out, 8'h04);
    chk("t3_pause_state", bus.state, 2'd2);
    repeat (5) cycle();
    chk("t3_frozen", bus.cnt_out, 8'h04);
    bus.clk_en = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("t3_resume", bus.state, 2'd1);

    // Clamp on load, idle ignores ticks, clr beats an expiring tick
    bus.load = 1'b1; bus.load_val = 8'hAF;
    cycle();
    bus.load = 1'b0; bus.clk_en = 1'b1;
    chk("t4_clamp", bus.cnt_out, 8'h99);
    cycle();
    bus.clk_en = 1'b0;
    chk("t4_idle_hold", bus.cnt_out, 8'h99);
    bus.load = 1'b1; bus.load_val = 8'h02;
    cycle();
    bus.load = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0; bus.clk_en = 1'b1;
    cycle();
    chk("t4_at_one", bus.cnt_out, 8'h01);
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0; bus.clk_en = 1'b0;
    chk("t4_clr_cnt", bus.cnt_out, 8'h00);
    chk("t4_clr_state", bus.state, 2'd0);
    chk("t4_clr_nodone", bus.done_pulse, 1'b0);
    cycle();
    chk("t4_clr_nodone2", bus.done_pulse, 1'b0);

    // Asynchronous reset in the middle of a clock period
    bus.load = 1'b1; bus.load_val = 8'h58;
    cycle();
    bus.load = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0; bus.clk_en = 1'b1;
    cycle();
    chk("t5_cnt", bus.cnt_out, 8'h57);
    chk("t5_run", bus.state, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_cnt", bus.cnt_out, 8'h00);
    chk("t5_async_state", bus.state, 2'd0);
    chk("t5_async_done", bus.done_pulse, 1'b0);
    bus.clk_en = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();

    // Repeated expiry: reload in RUN, or a single DONE
    bus.load = 1'b1; bus.load_val = 8'h03;
    cycle();
    bus.load = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0; bus.clk_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      k = i % 3;
`ifdef BCD_TIMER_RELOAD_EN
      e_cnt   = (k == 0) ? 8'h03 : 8'(3 - k);
      e_done  = (k == 0);
      e_state = 2'd1;
`else
      e_cnt   = (i < 3) ? 8'(3 - i) : 8'h00;
      e_done  = (i == 3);
      e_state = (i < 3) ? 2'd1 : 2'd3;
`endif
      chk("t6_cnt", bus.cnt_out, e_cnt);
      chk("t6_done", bus.done_pulse, e_done);
      chk("t6_state", bus.state, e_state);
    end
    bus.clk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
